// File: rtl/line_streamer_pkg.sv
// Shared types and helpers for the line streamer: FSM state encoding,
// address/count width functions and a saturating increment for statistics.
package line_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STAT_W = 16;

    function automatic int calc_aw(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int calc_lw(input int max_lines);
        return (max_lines < 1) ? 1 : $clog2(max_lines + 1);
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/line_streamer_fifo.sv
// Line buffer: FIFO_LINES entries of one full source line each, with the head
// line exposed combinationally so the serialiser can index into it.
module line_streamer_fifo #(
    parameter  int DATA_WIDTH = 16,
    parameter  int LINE_LEN   = 16,
    parameter  int FIFO_LINES = 2,
    localparam int CW         = $clog2(FIFO_LINES + 1),
    localparam int PW         = (FIFO_LINES <= 1) ? 1 : $clog2(FIFO_LINES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push_i,
    input  logic [LINE_LEN-1:0][DATA_WIDTH-1:0]  line_i,
    input  logic                                 pop_i,
    output logic [LINE_LEN-1:0][DATA_WIDTH-1:0]  head_o,
    output logic [CW-1:0]                        count_o,
    output logic                                 full_o,
    output logic                                 empty_o
);

    typedef logic [LINE_LEN-1:0][DATA_WIDTH-1:0] line_t;

    line_t         mem_q [FIFO_LINES];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_LINES - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(FIFO_LINES));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = ptr_next(wr_q);
        if (do_pop)  rd_d = ptr_next(rd_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Line storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= line_i;
    end

endmodule

// File: rtl/line_streamer.sv
// Fetches strided lines from the line ROM, buffers them and streams one word
// per cycle. Optional stall counters are enabled by LINE_STREAMER_STATS_EN.
module line_streamer
    import line_streamer_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int LINE_LEN   = 16,
    parameter  int MEM_DEPTH  = 256,
    parameter  int FIFO_LINES = 2,
    parameter  int MAX_LINES  = 64,
    localparam int AW         = calc_aw(MEM_DEPTH),
    localparam int LW         = calc_lw(MAX_LINES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [AW-1:0]                        base_addr,
    input  logic [AW-1:0]                        stride,
    input  logic [LW-1:0]                        num_lines,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic                                 src_fetch,
    output logic                                 src_use_ext,
    output logic [AW-1:0]                        src_addr,
    input  logic                                 src_ready,
    input  logic                                 src_valid,
    input  logic [LINE_LEN-1:0][DATA_WIDTH-1:0]  src_line,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_sol,
    output logic                                 out_last
`ifdef LINE_STREAMER_STATS_EN
    ,
    output logic [15:0]                          stall_src,
    output logic [15:0]                          stall_out
`endif
);

    localparam int CW = $clog2(FIFO_LINES + 1);
    localparam int WW = (LINE_LEN <= 1) ? 1 : $clog2(LINE_LEN);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [LW-1:0] num_q, num_d;
    logic [LW-1:0] issued_q, issued_d;
    logic [LW-1:0] popped_q, popped_d;
    logic [WW-1:0] word_q, word_d;
    logic          outst_q, outst_d;
    logic          err_q, err_d;

    logic [LINE_LEN-1:0][DATA_WIDTH-1:0] head_line;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;

    logic start_ok, room, fetch_want, push, pop, unsolicited;
    logic accept, line_end, last_line, final_accept;

    line_streamer_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_LEN   (LINE_LEN),
        .FIFO_LINES (FIFO_LINES)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .line_i  (src_line),
        .pop_i   (pop),
        .head_o  (head_line),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A fetch in flight reserves a FIFO slot so its line always has room.
    assign start_ok    = (state_q == IDLE) & start;
    assign room        = ~fifo_full & ((int'(fifo_count) + int'(outst_q)) < FIFO_LINES);
    assign fetch_want  = (state_q == RUN) & ~outst_q & (issued_q < num_q) & room;
    assign src_fetch   = fetch_want & src_ready;
    assign src_addr    = addr_q;
    assign src_use_ext = 1'b1;
    assign push        = src_valid & outst_q;
    assign unsolicited = src_valid & ~outst_q & (state_q == RUN);

    assign out_valid    = ~fifo_empty;
    assign accept       = out_valid & out_ready;
    assign line_end     = (word_q == WW'(LINE_LEN - 1));
    assign last_line    = (popped_q == num_q - LW'(1));
    assign pop          = accept & line_end;
    assign final_accept = pop & last_line;
    assign out_data     = head_line[word_q];
    assign out_sol      = out_valid & (word_q == '0);
    assign out_last     = out_valid & line_end & last_line;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_lines == '0) ? DONE : RUN;
            RUN:     if (final_accept) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        err  = err_q;
    end

    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        num_d    = num_q;
        issued_d = issued_q;
        popped_d = popped_q;
        word_d   = word_q;
        outst_d  = outst_q;
        err_d    = err_q;
        if (start_ok) begin
            addr_d   = base_addr;
            stride_d = stride;
            num_d    = num_lines;
            issued_d = '0;
            popped_d = '0;
            word_d   = '0;
            outst_d  = 1'b0;
            err_d    = 1'b0;
        end else begin
            if (src_fetch) begin
                addr_d   = addr_q + stride_q;
                issued_d = issued_q + LW'(1);
                outst_d  = 1'b1;
            end else if (push) begin
                outst_d  = 1'b0;
            end
            if (unsolicited) err_d = 1'b1;
            if (accept) begin
                word_d = line_end ? '0 : word_q + WW'(1);
                if (line_end) popped_d = popped_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            stride_q <= '0;
            num_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            word_q   <= '0;
            outst_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            word_q   <= word_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
        end
    end

`ifdef LINE_STREAMER_STATS_EN
    logic [STAT_W-1:0] stall_src_q, stall_src_d;
    logic [STAT_W-1:0] stall_out_q, stall_out_d;

    always_comb begin
        stall_src_d = stall_src_q;
        stall_out_d = stall_out_q;
        if (start_ok) begin
            stall_src_d = '0;
            stall_out_d = '0;
        end else begin
            if (fetch_want & ~src_ready)  stall_src_d = sat_inc(stall_src_q);
            if (out_valid & ~out_ready)   stall_out_d = sat_inc(stall_out_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_src_q <= '0;
            stall_out_q <= '0;
        end else begin
            stall_src_q <= stall_src_d;
            stall_out_q <= stall_out_d;
        end
    end

    assign stall_src = stall_src_q;
    assign stall_out = stall_out_q;
`endif

endmodule

// File: tb/tb_line_streamer.sv
// Bench for line_streamer: identity-content line ROM model, word scoreboard,
// table of streaming jobs plus hand-written corner sequences.
module tb_line_streamer;

    localparam int DW = 16;
    localparam int LL = 16;
    localparam int MD = 256;
    localparam int FL = 2;
    localparam int ML = 64;
    localparam int AW = 8;
    localparam int LW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, start;
    logic [AW-1:0]           base_addr, stride;
    logic [LW-1:0]           num_lines;
    logic                    busy, done, err;
    logic                    src_fetch, src_use_ext;
    logic [AW-1:0]           src_addr;
    logic                    src_ready, src_valid;
    logic [LL-1:0][DW-1:0]   src_line;
    logic [DW-1:0]           out_data;
    logic                    out_valid, out_ready, out_sol, out_last;
`ifdef LINE_STREAMER_STATS_EN
    logic [15:0]             stall_src, stall_out;
`endif

    line_streamer #(
        .DATA_WIDTH (DW),
        .LINE_LEN   (LL),
        .MEM_DEPTH  (MD),
        .FIFO_LINES (FL),
        .MAX_LINES  (ML)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .stride      (stride),
        .num_lines   (num_lines),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .src_fetch   (src_fetch),
        .src_use_ext (src_use_ext),
        .src_addr    (src_addr),
        .src_ready   (src_ready),
        .src_valid   (src_valid),
        .src_line    (src_line),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sol     (out_sol),
        .out_last    (out_last)
`ifdef LINE_STREAMER_STATS_EN
        ,
        .stall_src   (stall_src),
        .stall_out   (stall_out)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sol;
        logic          last;
    } exp_t;

    typedef struct {
        int   base;
        int   strd;
        int   n;
        int   smax;
        int   rmode;
        int   exp_words;
        logic exp_err;
    } job_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Source / sink model knobs, written by the main sequence.
    int   smin = 0, smax = 0, rmode = 0;
    bit   src_rand = 0, inject = 0;

    bit            fetch_seen = 0;
    logic [AW-1:0] fetch_addr_s;
    int            fetch_cnt = 0;
    int            acc_cnt = 0;
    int            last_cyc = 0, first_cyc = 0;
    bit            job_first = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endfunction

    // Line ROM model: accepts a fetch, answers after a random latency.
    initial begin
        bit            pend;
        int            cnt;
        logic [AW-1:0] paddr;
        pend = 0; cnt = 0; paddr = '0;
        src_valid = 1'b0; src_ready = 1'b1; out_ready = 1'b1; src_line = '0;
        forever begin
            @(posedge clk); #1;
            src_valid = 1'b0;
            if (fetch_seen) begin
                pend  = 1;
                paddr = fetch_addr_s;
                cnt   = $urandom_range(smax, smin);
            end
            if (pend) begin
                if (cnt == 0) begin
                    src_valid = 1'b1;
                    for (int i = 0; i < LL; i++) src_line[i] = DW'((int'(paddr) + i) % MD);
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            if (inject && !pend) begin
                src_valid = 1'b1;
                src_line  = '1;
                inject    = 0;
            end
            src_ready = src_rand ? 1'($urandom_range(1, 0)) : 1'b1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1, 0));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Handshake capture and output scoreboard, sampled mid-cycle.
    initial begin
        bit            hold_pend;
        logic [DW-1:0] h_data;
        logic          h_sol, h_last;
        exp_t          e;
        hold_pend = 0; h_data = '0; h_sol = 0; h_last = 0;
        forever begin
            @(negedge clk);
            fetch_seen   = (src_fetch === 1'b1);
            fetch_addr_s = src_addr;
            if (src_fetch === 1'b1) fetch_cnt++;
            if (hold_pend) begin
                n_tests++;
                if (!(out_valid === 1'b1 && out_data === h_data && out_sol === h_sol && out_last === h_last)) begin
                    n_fail++;
                    $display("FAIL hold: got v=%0b d=%0d sol=%0b last=%0b expected v=1 d=%0d sol=%0b last=%0b",
                             out_valid, out_data, out_sol, out_last, h_data, h_sol, h_last);
                end
            end
            hold_pend = (out_valid === 1'b1) && (out_ready === 1'b0);
            h_data = out_data; h_sol = out_sol; h_last = out_last;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                acc_cnt++;
                if (job_first) begin
                    first_cyc = cyc;
                    job_first = 0;
                end
                if (out_last === 1'b1) last_cyc = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL word: got unexpected word d=%0d expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_sol !== e.sol || out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL word: got d=%0d sol=%0b last=%0b expected d=%0d sol=%0b last=%0b",
                                 out_data, out_sol, out_last, e.data, e.sol, e.last);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int b, input int s, input int n);
        exp_t e;
        int   a;
        for (int k = 0; k < n; k++) begin
            a = (b + k * s) % MD;
            for (int i = 0; i < LL; i++) begin
                e.data = DW'((a + i) % MD);
                e.sol  = (i == 0);
                e.last = (k == n - 1) && (i == LL - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_job(input int b, input int s, input int n, output int scyc);
        push_exp(b, s, n);
        job_first = 1;
        @(posedge clk); #1;
        base_addr = AW'(b);
        stride    = AW'(s);
        num_lines = LW'(n);
        start     = 1'b1;
        scyc      = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        job_t jobs[4];
        int   scyc, fb, wb, late_v, late_e;
        bit   ok;

        jobs[0] = '{base: 0,   strd: 16,  n: 4, smax: 0, rmode: 0, exp_words: 64, exp_err: 1'b0};
        jobs[1] = '{base: 240, strd: 16,  n: 2, smax: 0, rmode: 0, exp_words: 32, exp_err: 1'b0};
        jobs[2] = '{base: 0,   strd: 16,  n: 4, smax: 5, rmode: 1, exp_words: 64, exp_err: 1'b0};
        jobs[3] = '{base: 8,   strd: 200, n: 3, smax: 5, rmode: 1, exp_words: 48, exp_err: 1'b0};

        rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; num_lines = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_fetch", src_fetch, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sol_last", {out_sol, out_last}, 0);
        chk("rst_src_addr", src_addr, 0);
        chk("use_ext", src_use_ext, 1);
        @(posedge clk); #1 rst = 1'b0;

        for (int j = 0; j < 4; j++) begin
            smin = 0; smax = jobs[j].smax; src_rand = (jobs[j].smax > 0); rmode = jobs[j].rmode;
            fb = fetch_cnt; wb = acc_cnt;
            start_job(jobs[j].base, jobs[j].strd, jobs[j].n, scyc);
            wait_done(3000, ok);
            chk($sformatf("job%0d_done_seen", j), ok, 1);
            chk($sformatf("job%0d_done_latency", j), cyc - last_cyc, 1);
            chk($sformatf("job%0d_words", j), acc_cnt - wb, jobs[j].exp_words);
            chk($sformatf("job%0d_err", j), err, jobs[j].exp_err);
            chk($sformatf("job%0d_queue_left", j), exp_q.size(), 0);
            chk($sformatf("job%0d_fetches", j), fetch_cnt - fb, jobs[j].n);
            if (jobs[j].smax == 0 && jobs[j].rmode == 0)
                chk($sformatf("job%0d_no_bubble", j), last_cyc - first_cyc, jobs[j].exp_words - 1);
            @(negedge clk);
            chk($sformatf("job%0d_done_pulse", j), {busy, done}, 0);
        end

        // Consumer stalled: the buffer fills to FIFO_LINES and fetching stops.
        smin = 0; smax = 0; src_rand = 0; rmode = 2;
        fb = fetch_cnt;
        start_job(0, 16, 8, scyc);
        repeat (100) @(negedge clk);
        chk("bp_fetches", fetch_cnt - fb, FL);
        chk("bp_valid_busy", {out_valid, busy}, 2'b11);
        chk("bp_head_word", out_data, exp_q[0].data);
        inject = 1;
        repeat (4) @(negedge clk);
        chk("unsolicited_err", err, 1);
        chk("unsolicited_no_fetch", fetch_cnt - fb, FL);
        chk("unsolicited_head_kept", out_data, exp_q[0].data);
        rmode = 1;
        wait_done(3000, ok);
        chk("bp_done_seen", ok, 1);
        chk("bp_queue_left", exp_q.size(), 0);
        chk("bp_total_fetches", fetch_cnt - fb, 8);
        chk("err_sticky", err, 1);

        // A start while busy must be ignored; the accepted start clears err.
        smax = 2; src_rand = 1; rmode = 1;
        fb = fetch_cnt;
        start_job(16, 16, 3, scyc);
        @(negedge clk);
        chk("start_clears_err", err, 0);
        repeat (10) @(negedge clk);
        chk("busy_mid_job", busy, 1);
        @(posedge clk); #1;
        base_addr = AW'(100); stride = AW'(1); num_lines = LW'(1); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(3000, ok);
        chk("ignored_start_done_seen", ok, 1);
        chk("ignored_start_fetches", fetch_cnt - fb, 3);
        chk("ignored_start_queue", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        chk("ignored_start_idle", {busy, out_valid}, 0);
        chk("ignored_start_no_refetch", fetch_cnt - fb, 3);

        // Empty job: no fetch, done right after the start is sampled.
        smax = 0; src_rand = 0; rmode = 0;
        fb = fetch_cnt;
        start_job(0, 16, 0, scyc);
        wait_done(10, ok);
        chk("zero_done_seen", ok, 1);
        chk("zero_done_cycle", cyc - scyc, 1);
        chk("zero_fetches", fetch_cnt - fb, 0);
        chk("zero_no_output", out_valid, 0);

        // Reset with a fetch outstanding; the late source response is dropped.
        smin = 5; smax = 5;
        fb = fetch_cnt;
        start_job(0, 16, 4, scyc);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (src_fetch === 1'b1);
        end
        chk("rst_job_fetch_seen", ok, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy_done", {busy, done}, 0);
        chk("midrst_out", {out_valid, out_sol, out_last}, 0);
        chk("midrst_fetch_addr", {src_fetch, src_addr}, 0);
        exp_q.delete();
        late_v = 0; late_e = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) late_v++;
            if (err === 1'b1) late_e++;
        end
        chk("late_valid_no_output", late_v, 0);
        chk("late_valid_no_err", late_e, 0);

        smin = 0; smax = 0;
        fb = fetch_cnt;
        start_job(32, 16, 1, scyc);
        wait_done(200, ok);
        chk("recover_done_seen", ok, 1);
        chk("recover_queue", exp_q.size(), 0);
        chk("recover_fetches", fetch_cnt - fb, 1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "time limit");
    end

endmodule
